// File: rtl/mt_pkg.sv
// Shared MT19937 tempering constants and per-stage tempering helper.
// Also used by the twist stage, so keep the constants here rather than in any one module.
package mt_pkg;

  localparam int MT_W = 32;
  localparam int MT_U = 11;
  localparam int MT_S = 7;
  localparam int MT_T = 15;
  localparam int MT_L = 18;
  localparam logic [MT_W-1:0] MT_B = 32'h9D2C5680;
  localparam logic [MT_W-1:0] MT_C = 32'hEFC60000;

  // Stage 0 holds the raw word; stages 1..4 hold the tempering results.
  localparam int MT_NUM_STAGES = 5;

  typedef logic [MT_W-1:0] mt_word_t;

  typedef struct packed {
    logic     vld;
    mt_word_t data;
  } mt_stage_t;

  // One tempering operation; idx selects which of the four.
  function automatic mt_word_t mt_temper_step(input logic [1:0] idx, input mt_word_t y);
    mt_word_t r;
    case (idx)
      2'd0:    r = y ^ (y >> MT_U);
      2'd1:    r = y ^ ((y << MT_S) & MT_B);
      2'd2:    r = y ^ ((y << MT_T) & MT_C);
      default: r = y ^ (y >> MT_L);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mt_sync_fifo.sv
// Synchronous FIFO, DEPTH x W, with sync reset, sync clear and an occupancy count.
// Reading an empty FIFO presents zero on the data output.
module mt_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty && !i_clear;
  assign w_push_ok = i_push && (!w_full || w_pop_ok) && !i_clear;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/mt_temper_buffer.sv
// MT19937 tempering pipeline feeding an output FIFO, with credit-based input flow
// control and a batch counter that tells the twister when to re-start.
module mt_temper_buffer
  import mt_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_WORDS = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  input  logic [MT_W-1:0] i_in_data,
  output logic            o_in_ready,
  output logic            o_out_valid,
  output logic [MT_W-1:0] o_out_data,
  input  logic            i_out_ready,
  output logic [15:0]     o_word_count,
  output logic            o_batch_done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(DEPTH + MT_NUM_STAGES + 1) + 1;
  localparam logic [16:0] NW = 17'(NUM_WORDS);

  mt_stage_t r_stage [MT_NUM_STAGES];

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic [SW-1:0] w_pipe_count;
  logic [SW-1:0] w_inflight;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_fifo_push;
  logic [16:0]   w_wc_next;

  logic [15:0]   r_word_count;
  logic          r_batch_done;

  // Every accepted word holds a credit until it leaves the FIFO, so the FIFO can never overflow.
  always_comb begin
    w_pipe_count = '0;
    for (int i = 0; i < MT_NUM_STAGES; i++) begin
      w_pipe_count = w_pipe_count + SW'(r_stage[i].vld);
    end
  end

  assign w_inflight = SW'(w_fifo_count) + w_pipe_count;
  assign o_in_ready = (w_inflight < SW'(DEPTH));

  assign w_in_fire   = i_in_valid && o_in_ready && !i_flush;
  assign w_out_fire  = o_out_valid && i_out_ready && !i_flush;
  assign w_fifo_push = r_stage[MT_NUM_STAGES-1].vld && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int i = 0; i < MT_NUM_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= '{vld: w_in_fire, data: i_in_data};
      for (int i = 1; i < MT_NUM_STAGES; i++) begin
        r_stage[i] <= '{vld:  r_stage[i-1].vld,
                        data: mt_temper_step(2'(i-1), r_stage[i-1].data)};
      end
    end
  end

  mt_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (MT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_flush),
    .i_push      (w_fifo_push),
    .i_push_data (r_stage[MT_NUM_STAGES-1].data),
    .i_pop       (w_out_fire),
    .o_pop_data  (o_out_data),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  assign o_out_valid = !w_fifo_empty;

  assign w_wc_next = {1'b0, r_word_count} + 17'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_word_count <= '0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      if (w_out_fire) begin
        if (w_wc_next == NW) begin
          r_word_count <= '0;
          r_batch_done <= 1'b1;
        end else begin
          r_word_count <= w_wc_next[15:0];
        end
      end
    end
  end

  assign o_word_count = r_word_count;
  assign o_batch_done = r_batch_done;

endmodule

// File: tb/tb_mt_temper_buffer.sv
// Bench for mt_temper_buffer: directed scenarios plus a random stream, all checked
// every cycle against a queue-based model of accepted-but-undelivered words.
module tb_mt_temper_buffer;

  localparam int DEPTH = 4;
  localparam int NW    = 2;

  logic        clk = 1'b0;
  logic        i_rst, i_flush, i_in_valid, i_out_ready;
  logic [31:0] i_in_data;
  logic        o_in_ready, o_out_valid, o_batch_done;
  logic [31:0] o_out_data;
  logic [15:0] o_word_count;

  always #5 clk = ~clk;

  mt_temper_buffer #(.DEPTH(DEPTH), .NUM_WORDS(NW)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_out_valid  (o_out_valid),
    .o_out_data   (o_out_data),
    .i_out_ready  (i_out_ready),
    .o_word_count (o_word_count),
    .o_batch_done (o_batch_done)
  );

  typedef struct {
    logic [31:0] d;
    int          acc;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   m_wc = 0;
  bit   m_done = 0;
  bit   last_acc, last_dlv;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [31:0] temper(input logic [31:0] y);
    logic [31:0] t;
    t = y ^ (y >> 11);
    t = t ^ ((t << 7) & 32'h9D2C5680);
    t = t ^ ((t << 15) & 32'hEFC60000);
    t = t ^ (t >> 18);
    return t;
  endfunction

  // Head word is visible once five edges have passed since it was accepted.
  function automatic bit m_out_valid();
    return (q.size() > 0) && (cyc >= q[0].acc + 5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_data;
    bit          exp_ov;
    exp_ov   = m_out_valid();
    exp_data = 32'h0;
    if (exp_ov) exp_data = q[0].d;
    chk("in_ready",   32'(o_in_ready),   32'(q.size() < DEPTH));
    chk("out_valid",  32'(o_out_valid),  32'(exp_ov));
    chk("out_data",   o_out_data,        exp_data);
    chk("word_count", 32'(o_word_count), 32'(m_wc));
    chk("batch_done", 32'(o_batch_done), 32'(m_done));
  endtask

  task automatic step(input bit r, input bit f, input bit iv, input logic [31:0] d, input bit ordy);
    bit acc, dlv;
    i_rst = r; i_flush = f; i_in_valid = iv; i_in_data = d; i_out_ready = ordy;
    acc = iv && (q.size() < DEPTH);
    dlv = m_out_valid() && ordy;
    @(posedge clk);
    cyc++;
    if (r || f) begin
      q.delete();
      m_wc   = 0;
      m_done = 0;
      acc    = 0;
      dlv    = 0;
    end else begin
      m_done = 0;
      if (dlv) begin
        void'(q.pop_front());
        m_wc++;
        if (m_wc == NW) begin
          m_wc   = 0;
          m_done = 1;
        end
      end
      if (acc) q.push_back('{temper(d), cyc});
    end
    last_acc = acc;
    last_dlv = dlv;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, ordy);
  endtask

  initial begin
    int nacc, ndlv, cycles;
    bit seen;
    logic [31:0] got [8];
    logic [15:0] wc_seq [6];
    bit          dn_seq [6];
    int          exp_wc [6];
    int          exp_dn [6];
    exp_wc = '{1, 0, 1, 0, 1, 0};
    exp_dn = '{0, 1, 0, 1, 0, 1};

    i_rst = 1; i_flush = 0; i_in_valid = 0; i_in_data = 0; i_out_ready = 0;

    // Reset state
    step(1, 0, 0, 32'h0, 0);
    chk("rst_out_valid", 32'(o_out_valid), 32'h0);
    chk("rst_in_ready",  32'(o_in_ready),  32'h1);
    chk("rst_out_data",  o_out_data,       32'h0);

    // Single word latency and known tempered value
    step(0, 0, 1, 32'h00000001, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 0);
      chk("lat_early_valid", 32'(o_out_valid), 32'h0);
    end
    step(0, 0, 0, 32'h0, 0);
    chk("lat_valid", 32'(o_out_valid), 32'h1);
    chk("one_data",  o_out_data,       32'h00400091);
    step(0, 0, 0, 32'h0, 1);
    chk("one_wc", 32'(o_word_count), 32'd1);

    // Zero word; its delivery completes a batch of two
    step(0, 0, 1, 32'h00000000, 0);
    idle(5, 0);
    chk("zero_valid", 32'(o_out_valid), 32'h1);
    chk("zero_data",  o_out_data,       32'h0);
    step(0, 0, 0, 32'h0, 1);
    chk("zero_done", 32'(o_batch_done), 32'h1);
    chk("zero_wc",   32'(o_word_count), 32'd0);

    // Backpressure: exactly DEPTH accepts, then drain in order
    step(1, 0, 0, 32'h0, 0);
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 32'(100 + nacc), 0);
      if (last_acc) nacc++;
    end
    chk("bp_accepts",  32'(nacc),        32'(DEPTH));
    chk("bp_in_ready", 32'(o_in_ready),  32'h0);
    ndlv = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_out_valid && ndlv < 8) got[ndlv] = o_out_data;
      step(0, 0, 0, 32'h0, 1);
      if (last_dlv) ndlv++;
    end
    chk("bp_drained", 32'(ndlv), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) chk("bp_order", got[k], temper(32'(100 + k)));

    // Batch sequence over six deliveries
    step(1, 0, 0, 32'h0, 0);
    nacc = 0; ndlv = 0; cycles = 0;
    while (ndlv < 6 && cycles < 60) begin
      step(0, 0, (nacc < 6), $urandom, 1);
      if (last_acc) nacc++;
      if (last_dlv) begin
        wc_seq[ndlv] = o_word_count;
        dn_seq[ndlv] = o_batch_done;
        ndlv++;
      end
      cycles++;
    end
    chk("batch_deliveries", 32'(ndlv), 32'd6);
    for (int k = 0; k < 6 && k < ndlv; k++) begin
      chk("batch_wc",   32'(wc_seq[k]), 32'(exp_wc[k]));
      chk("batch_done", 32'(dn_seq[k]), 32'(exp_dn[k]));
    end

    // Flush, then reset, with three words in flight
    for (int pass = 0; pass < 2; pass++) begin
      step(1, 0, 0, 32'h0, 0);
      step(0, 0, 1, 32'hAAAA0001, 0);
      step(0, 0, 1, 32'hAAAA0002, 0);
      step(0, 0, 1, 32'hAAAA0003, 0);
      step(pass == 1, pass == 0, 1, 32'hAAAA0004, 1);
      chk("flush_out_valid", 32'(o_out_valid),  32'h0);
      chk("flush_in_ready",  32'(o_in_ready),   32'h1);
      chk("flush_wc",        32'(o_word_count), 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        step(0, 0, 0, 32'h0, 1);
        if (o_out_valid) seen = 1;
      end
      chk("flush_stale", 32'(seen), 32'h0);
    end

    // Flush coinciding with an output handshake: word dropped, not counted
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h12345678, 0);
    idle(5, 0);
    step(0, 1, 0, 32'h0, 1);
    chk("flush_hs_wc",    32'(o_word_count), 32'd0);
    chk("flush_hs_valid", 32'(o_out_valid),  32'h0);
    chk("flush_hs_done",  32'(o_batch_done), 32'h0);

    // Fill to full, then stream with push and pop together
    for (int i = 0; i < 10; i++) step(0, 0, 1, $urandom, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, $urandom, 1);
    idle(8, 1);

    // 1000-word random stream with the consumer always ready
    nacc = 0; cycles = 0;
    while (nacc < 1000 && cycles < 5000) begin
      step(0, 0, 1, $urandom, 1);
      if (last_acc) nacc++;
      cycles++;
    end
    chk("stream_accepts", 32'(nacc), 32'd1000);
    idle(8, 1);

    // Random mix of backpressure, flushes and resets
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
    end
    idle(10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
